// File: rtl/uart_tx_queue.sv
// Byte FIFO and launch controller feeding a UART transmitter through a din/wr_en/tx_busy handshake.
// Optional overflow statistics (ovf_sticky, drop_count, ovf_clear) are built when UART_TXQ_OVF_STATS_EN is defined.
module uart_tx_queue #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned BUSY_TIMEOUT = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [7:0]               push_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               din,
    output logic                     wr_en,
    input  logic                     tx_busy,
`ifdef UART_TXQ_OVF_STATS_EN
    input  logic                     ovf_clear,
    output logic                     ovf_sticky,
    output logic [7:0]               drop_count,
`endif
    output logic                     busy_timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(BUSY_TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;

    state_e        state_q;
    logic [TW-1:0] tmo_q;
    logic [TW-1:0] tmo_inc_c;
    logic [7:0]    din_q;
    logic          wr_en_q;
    logic          busy_timeout_q;

    logic          push_ok_c;
    logic          pop_c;

    // Launch decision uses only registered FIFO flags so outputs never depend combinationally on inputs.
    always_comb begin
        push_ok_c = push && !full_q;
        pop_c     = (state_q == ST_IDLE) && !empty_q && !tx_busy;
        tmo_inc_c = tmo_q + TW'(1);
        wptr_d    = push_ok_c ? wptr_q + AW'(1) : wptr_q;
        rptr_d    = pop_c ? rptr_q + AW'(1) : rptr_q;
        unique case ({push_ok_c, pop_c})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CW'(DEPTH));
        empty_d = (count_d == CW'(0));
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Launch FSM: one-cycle wr_en, then wait for the transmitter to go busy and idle again.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            tmo_q          <= '0;
            din_q          <= 8'h00;
            wr_en_q        <= 1'b0;
            busy_timeout_q <= 1'b0;
        end else begin
            wr_en_q        <= 1'b0;
            busy_timeout_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (pop_c) begin
                        din_q   <= mem_q[rptr_q];
                        wr_en_q <= 1'b1;
                        tmo_q   <= '0;
                        state_q <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_q <= ST_WAIT_DONE;
                    end else if (tmo_inc_c == TW'(BUSY_TIMEOUT)) begin
                        // Byte is abandoned, not re-queued.
                        busy_timeout_q <= 1'b1;
                        tmo_q          <= '0;
                        state_q        <= ST_IDLE;
                    end else begin
                        tmo_q <= tmo_inc_c;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef UART_TXQ_OVF_STATS_EN
    logic       ovf_sticky_q;
    logic [7:0] drop_count_q;

    // Clear has priority over a drop on the same edge; counter saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky_q <= 1'b0;
            drop_count_q <= 8'h00;
        end else if (ovf_clear) begin
            ovf_sticky_q <= 1'b0;
            drop_count_q <= 8'h00;
        end else if (push && full_q) begin
            ovf_sticky_q <= 1'b1;
            if (drop_count_q != 8'hFF) begin
                drop_count_q <= drop_count_q + 8'd1;
            end
        end
    end

    assign ovf_sticky = ovf_sticky_q;
    assign drop_count = drop_count_q;
`endif

    assign full         = full_q;
    assign empty        = empty_q;
    assign count        = count_q;
    assign din          = din_q;
    assign wr_en        = wr_en_q;
    assign busy_timeout = busy_timeout_q;

endmodule
